sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning the word width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 7, meaning the word-address width (depth 2**ADDR_WIDTH).
REQ-003 The block SHALL have port clk0, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have ports a_valid/a_ready (in/out, 1), a_addr (in, ADDR_WIDTH), a_rvalid (out, 1) and a_rdata (out, DATA_WIDTH): requester A, read-only (fetch).
REQ-006 The block SHALL have ports b_valid/b_ready (in/out, 1), b_we (in, 1), b_addr (in, ADDR_WIDTH), b_wdata (in, DATA_WIDTH), b_rvalid (out, 1) and b_rdata (out, DATA_WIDTH): requester B, read/write (data).
REQ-007 The block SHALL have ports clr (in, 1), a scrub request, and clr_busy (out, 1), high while scrubbing.
REQ-008 The block SHALL have SRAM-side ports sram_csb0 (out, 1, active low), sram_web0 (out, 1, active low), sram_addr0 (out, ADDR_WIDTH), sram_din0 (out, DATA_WIDTH) and sram_dout0 (in, DATA_WIDTH).

Function
REQ-009 States: RUN and SCRUB; RUN → SCRUB when clr=1 is sampled in RUN; SCRUB → RUN after the write to the last address.
REQ-010 In RUN, at most one request is granted per cycle; a transfer occurs when valid && ready are high at a rising edge.
REQ-011 a_ready/b_ready: combinational from the grant; ready is never high for a requester whose valid is low; both ready signals are 0 in SCRUB and during reset.
REQ-012 SRAM controls are combinational from the granted request: sram_csb0=0; sram_web0=~b_we for B and 1 for A; sram_addr0/sram_din0 are taken from the winner.
REQ-013 When no request is granted: sram_csb0=1, sram_web0=1, and sram_addr0/sram_din0 are 0.
REQ-014 Read latency is 1 cycle: x_rvalid is a registered pulse in the cycle after the accepted read, with x_rdata=sram_dout0 in that cycle.
REQ-015 x_rdata SHALL be 0 whenever x_rvalid=0.
REQ-016 Writes produce no rvalid.
REQ-017 Responses have no backpressure; requesters must accept them.
REQ-018 Back-to-back accepted reads SHALL give back-to-back rvalid pulses in issue order, with no bubble.
REQ-019 Arbitration is fixed priority, B over A, unless the macro in REQ-030 is defined.
REQ-020 A read and a write to the same address in consecutive cycles SHALL return the new data, because SRAM writes complete at the negedge.
REQ-021 SCRUB: a 7-bit (ADDR_WIDTH) counter starts at 0 and writes din=0 to each address, one per cycle, for 2**ADDR_WIDTH cycles; clr_busy=1 throughout.
REQ-022 clr sampled during SCRUB SHALL be ignored, with no restart.
REQ-023 A read accepted in the cycle in which clr is sampled completes normally; its rvalid appears in the first SCRUB cycle.
REQ-024 Address counter wrap from 2**ADDR_WIDTH-1 SHALL end SCRUB; the counter SHALL NOT write address 0 twice.

Reset
REQ-025 While rst_n=0: state=RUN, scrub counter=0, a_rvalid=b_rvalid=0, clr_busy=0, sram_csb0=1, sram_web0=1, a_ready=b_ready=0.
REQ-026 Reset assertion mid-SCRUB or with a read in flight SHALL abort immediately; the pending rvalid is discarded and partly scrubbed contents are left as-is.
REQ-027 The first grant SHALL be possible in the first cycle after rst_n deasserts.
REQ-028 The round-robin pointer (REQ-030) resets to favour A.

Configuration
REQ-029 Macro SRAM_ARB_RR_EN compiles round-robin arbitration in or out.
REQ-030 With SRAM_ARB_RR_EN defined: on contention the grant alternates, a 1-bit pointer toggles after every contended grant, and the pointer is unchanged when only one requester is valid.
REQ-031 Without SRAM_ARB_RR_EN: fixed priority B over A with no pointer register; A may starve.

Verification
REQ-032 Reset, then A reads address 5 with the memory preloaded with 0xDEADBEEF → sram_csb0=0, web0=1, addr0=5 in cycle 0; a_rvalid=1 with a_rdata=0xDEADBEEF in cycle 1.
REQ-033 B writes 0x12345678 to address 10, then B reads address 10 in the next cycle → b_rvalid in cycle 2 with 0x12345678; no rvalid for the write.
REQ-034 A and B both valid, reading for 4 cycles → without the macro: B granted 4/4 and a_ready=0; with SRAM_ARB_RR_EN: grants A,B,A,B.
REQ-035 Pulse clr → clr_busy=1 for exactly 128 cycles; ready=0 throughout; afterwards a read of address 127 returns 0.
REQ-036 Assert rst_n=0 at scrub count 40 → all outputs take reset values asynchronously; after release the state is RUN and a_ready follows a_valid.
REQ-037 A issues 3 back-to-back reads at addresses 1,2,3 → a_rvalid high for 3 consecutive cycles with the data in order.

Source files
------------

// File: rtl/sram_arbiter.sv
// Two-requester arbiter in front of a single-port SRAM, with a full-array scrub (zero-fill).
// Latency: reads return 1 cycle after acceptance (a_rvalid/b_rvalid pulse); writes complete silently.
// Backpressure: a_ready/b_ready combinational from the grant, both low while scrubbing; responses cannot be stalled.
//
// Ports:
//   clk0, rst_n                : clock, asynchronous active-low reset
//   a_valid/a_ready/a_addr     : requester A read request (fetch)
//   a_rvalid/a_rdata           : requester A read response
//   b_valid/b_ready/b_we/...   : requester B read/write request (data)
//   b_rvalid/b_rdata           : requester B read response
//   clr/clr_busy               : scrub request / scrub in progress
//   sram_*0                    : single-port SRAM macro interface (csb/web active low)
//
// Build option: define SRAM_ARB_RR_EN for round-robin arbitration on contention;
// otherwise B has fixed priority over A.
module sram_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk0,
  input  logic                  rst_n,
  // requester A (read only)
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  // requester B (read/write)
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  // scrub control
  input  logic                  clr,
  output logic                  clr_busy,
  // SRAM side
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
);

  typedef enum logic {
    RUN   = 1'b0,
    SCRUB = 1'b1
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  state_t                state;
  logic [ADDR_WIDTH-1:0] scrub_cnt;
  logic                  run_ok;
  logic                  gnt_a;
  logic                  gnt_b;

  // rst_n gates the grant so ready stays low for the whole reset window,
  // not just after the first edge.
  assign run_ok = rst_n && (state == RUN);

`ifdef SRAM_ARB_RR_EN
  // 0: A wins the next contended cycle, 1: B wins it.
  logic rr_fav_b;

  assign gnt_b = run_ok && b_valid && (!a_valid || rr_fav_b);
  assign gnt_a = run_ok && a_valid && (!b_valid || !rr_fav_b);

  // Only contended grants move the pointer; a lone requester leaves it alone.
  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      rr_fav_b <= 1'b0;
    end else if (run_ok && a_valid && b_valid) begin
      rr_fav_b <= ~rr_fav_b;
    end
  end
`else
  assign gnt_b = run_ok && b_valid;
  assign gnt_a = run_ok && a_valid && !b_valid;
`endif

  assign a_ready = gnt_a;
  assign b_ready = gnt_b;

  // SRAM command mux: scrub owns the port, otherwise the winner drives it.
  always_comb begin
    sram_csb0  = 1'b1;
    sram_web0  = 1'b1;
    sram_addr0 = '0;
    sram_din0  = '0;
    if (rst_n && (state == SCRUB)) begin
      sram_csb0  = 1'b0;
      sram_web0  = 1'b0;
      sram_addr0 = scrub_cnt;
    end else if (gnt_b) begin
      sram_csb0  = 1'b0;
      sram_web0  = ~b_we;
      sram_addr0 = b_addr;
      sram_din0  = b_wdata;
    end else if (gnt_a) begin
      sram_csb0  = 1'b0;
      sram_addr0 = a_addr;
    end
  end

  // Control FSM plus response pipeline. A read granted in the same cycle
  // that clr is sampled still gets its rvalid in the first SCRUB cycle.
  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      scrub_cnt <= '0;
      clr_busy  <= 1'b0;
      a_rvalid  <= 1'b0;
      b_rvalid  <= 1'b0;
    end else begin
      a_rvalid <= gnt_a;
      b_rvalid <= gnt_b && !b_we;
      case (state)
        RUN: begin
          if (clr) begin
            state     <= SCRUB;
            scrub_cnt <= '0;
            clr_busy  <= 1'b1;
          end
        end
        SCRUB: begin
          // clr is deliberately not looked at here: no restart mid-scrub.
          if (scrub_cnt == LAST_ADDR) begin
            state     <= RUN;
            scrub_cnt <= '0;
            clr_busy  <= 1'b0;
          end else begin
            scrub_cnt <= scrub_cnt + 1'b1;
          end
        end
        default: begin
          state    <= RUN;
          clr_busy <= 1'b0;
        end
      endcase
    end
  end

  // Data is only presented alongside its valid pulse.
  assign a_rdata = a_rvalid ? sram_dout0 : '0;
  assign b_rdata = b_rvalid ? sram_dout0 : '0;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: SRAM behavioural model, reference model, random traffic.
// Latency: checks read responses one cycle after each accepted read.
// Backpressure: requesters are held by the bench until the comb ready is sampled each cycle.
module tb_sram_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 7;
  localparam int DEPTH = 1 << AW;
`ifdef SRAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk0 = 1'b0;
  logic          rst_n;
  logic          a_valid, a_ready, a_rvalid;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_rdata;
  logic          b_valid, b_ready, b_we, b_rvalid;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata, b_rdata;
  logic          clr, clr_busy;
  logic          sram_csb0, sram_web0;
  logic [AW-1:0] sram_addr0;
  logic [DW-1:0] sram_din0, sram_dout0;

  always #5 clk0 = ~clk0;

  sram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk0(clk0), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr),
    .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr),
    .b_wdata(b_wdata), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .clr(clr), .clr_busy(clr_busy),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_addr0(sram_addr0),
    .sram_din0(sram_din0), .sram_dout0(sram_dout0)
  );

  // SRAM macro model: commands registered at posedge, reads drive dout at
  // the next posedge, writes land at the following negedge.
  logic [DW-1:0] sram_mem [DEPTH];
  logic          csb_q = 1'b1, web_q = 1'b1;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] din_q;

  always @(posedge clk0) begin
    csb_q  <= sram_csb0;
    web_q  <= sram_web0;
    addr_q <= sram_addr0;
    din_q  <= sram_din0;
    if (!sram_csb0 && sram_web0) sram_dout0 <= sram_mem[sram_addr0];
  end

  always @(negedge clk0) begin
    if (!csb_q && !web_q) sram_mem[addr_q] <= din_q;
  end

  // Reference model: plain memory array plus the arbitration rule.
  logic [DW-1:0] model_mem [DEPTH];
  bit            favor_a;
  bit            exp_a_v, exp_b_v;
  logic [DW-1:0] exp_a_d, exp_b_d;
  logic          obs_a_rdy;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Called at posedge+1 with inputs applied; checks last cycle's response,
  // this cycle's grant and SRAM command, advances the model, then one edge.
  task automatic do_cycle();
    bit ga, gb;
    #1;
    check("a_rvalid", a_rvalid, exp_a_v);
    check("a_rdata", a_rdata, exp_a_v ? exp_a_d : '0);
    check("b_rvalid", b_rvalid, exp_b_v);
    check("b_rdata", b_rdata, exp_b_v ? exp_b_d : '0);
    if (a_valid && b_valid) begin
      if (RR) begin
        ga = favor_a;
        favor_a = !favor_a;
      end else begin
        ga = 1'b0;
      end
      gb = !ga;
    end else begin
      ga = a_valid;
      gb = b_valid;
    end
    obs_a_rdy = a_ready;
    check("a_ready", a_ready, ga);
    check("b_ready", b_ready, gb);
    check("csb0", sram_csb0, !(ga || gb));
    check("web0", sram_web0, gb ? !b_we : 1'b1);
    check("addr0", sram_addr0, gb ? b_addr : (ga ? a_addr : '0));
    check("din0", sram_din0, gb ? b_wdata : '0);
    exp_a_v = ga;
    exp_a_d = model_mem[a_addr];
    if (gb && b_we) model_mem[b_addr] = b_wdata;
    exp_b_v = gb && !b_we;
    exp_b_d = model_mem[b_addr];
    @(posedge clk0); #1;
  endtask

  task automatic idle_inputs();
    a_valid = 0; b_valid = 0; b_we = 0; clr = 0;
  endtask

  // Asserts reset mid-cycle, checks immediate reset values, releases it and
  // confirms a request is granted straight away.
  task automatic reset_and_check();
    a_valid = 1; b_valid = 1; b_we = 0;
    rst_n = 0;
    #1;
    check("rst_a_ready", a_ready, 0);
    check("rst_b_ready", b_ready, 0);
    check("rst_csb0", sram_csb0, 1);
    check("rst_web0", sram_web0, 1);
    check("rst_clr_busy", clr_busy, 0);
    check("rst_a_rvalid", a_rvalid, 0);
    check("rst_b_rvalid", b_rvalid, 0);
    check("rst_a_rdata", a_rdata, 0);
    repeat (2) @(posedge clk0);
    @(negedge clk0);
    rst_n = 1;
    favor_a = 1; exp_a_v = 0; exp_b_v = 0;
    b_valid = 0;
    #1;
    check("post_rst_a_ready", a_ready, 1);
    check("post_rst_b_ready", b_ready, 0);
    a_valid = 0;
    #1;
    check("post_rst_a_idle", a_ready, 0);
    check("post_rst_busy", clr_busy, 0);
    @(posedge clk0); #1;
  endtask

  // Scrub with an A read accepted in the clr cycle; abort_at<0 runs to completion.
  task automatic run_scrub(input int abort_at);
    int busy = 0;
    idle_inputs();
    clr = 1; a_valid = 1; a_addr = 7'd3;
    do_cycle();
    clr = 0;
    for (int i = 0; i < 200; i++) begin
      a_valid = 1; b_valid = 1; b_we = 0; a_addr = 7'd9; b_addr = 7'd9;
      clr = (i == 5);
      #1;
      if (i == 0) begin
        check("scrub_first_rvalid", a_rvalid, 1);
        check("scrub_first_rdata", a_rdata, exp_a_d);
      end
      if (!clr_busy) break;
      busy++;
      check("scrub_a_ready", a_ready, 0);
      check("scrub_b_ready", b_ready, 0);
      check("scrub_csb0", sram_csb0, 0);
      check("scrub_web0", sram_web0, 0);
      check("scrub_addr0", sram_addr0, i[AW-1:0]);
      check("scrub_din0", sram_din0, 0);
      if (i == abort_at) begin
        reset_and_check();
        return;
      end
      @(posedge clk0); #1;
    end
    check("scrub_busy_cycles", busy, DEPTH);
    idle_inputs();
    exp_a_v = 0; exp_b_v = 0;
    for (int k = 0; k < DEPTH; k++) model_mem[k] = '0;
  endtask

  initial begin
    idle_inputs();
    a_addr = 0; b_addr = 0; b_wdata = 0;
    favor_a = 1; exp_a_v = 0; exp_b_v = 0; exp_a_d = 0; exp_b_d = 0;
    for (int k = 0; k < DEPTH; k++) begin
      logic [DW-1:0] v;
      v = $urandom;
      sram_mem[k] <= v;
      model_mem[k] = v;
    end
    rst_n = 0;
    #2;
    reset_and_check();

    // Single A read of a preloaded word.
    sram_mem[5] <= 32'hDEADBEEF; model_mem[5] = 32'hDEADBEEF;
    a_valid = 1; a_addr = 7'd5;
    do_cycle();
    idle_inputs();
    do_cycle();

    // B write then immediate read-back of the same address.
    b_valid = 1; b_we = 1; b_addr = 7'd10; b_wdata = 32'h12345678;
    do_cycle();
    b_we = 0;
    do_cycle();
    idle_inputs();
    do_cycle();
    do_cycle();

    // Four cycles of contention.
    a_valid = 1; b_valid = 1; b_we = 0; a_addr = 7'd20; b_addr = 7'd21;
    for (int i = 0; i < 4; i++) begin
      do_cycle();
      check("arb_pattern", obs_a_rdy, RR ? ((i % 2) == 0) : 1'b0);
    end
    idle_inputs();
    do_cycle();

    // Three back-to-back A reads.
    for (int k = 1; k <= 3; k++) begin
      sram_mem[k] <= 32'hA000_0000 + k; model_mem[k] = 32'hA000_0000 + k;
    end
    for (int k = 1; k <= 3; k++) begin
      a_valid = 1; a_addr = k[AW-1:0];
      do_cycle();
    end
    idle_inputs();
    do_cycle();
    do_cycle();

    // Random traffic over a small address window to force read-after-write.
    for (int n = 0; n < 400; n++) begin
      a_valid = 1'($urandom_range(0, 1));
      b_valid = 1'($urandom_range(0, 1));
      b_we    = 1'($urandom_range(0, 1));
      a_addr  = 7'($urandom_range(0, 15));
      b_addr  = 7'($urandom_range(0, 15));
      b_wdata = $urandom;
      do_cycle();
    end
    idle_inputs();
    do_cycle();

    // Reset while a read response is in flight.
    a_valid = 1; a_addr = 7'd7;
    do_cycle();
    check("inflight_rvalid", a_rvalid, 1);
    reset_and_check();

    // Full scrub, then read the last address.
    run_scrub(-1);
    a_valid = 1; a_addr = 7'd127;
    do_cycle();
    idle_inputs();
    do_cycle();

    // Scrub aborted by reset at count 40, then normal operation resumes.
    run_scrub(40);
    idle_inputs();
    a_valid = 1; a_addr = 7'd127;
    do_cycle();
    idle_inputs();
    do_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
